spi_sniffer_sync: RTL and testbench

//  Passive SPI bus sniffer, fully in the system clock domain. Oversamples sck/cs/mosi/miso
//  and assembles bytes. Emits a one-cycle data-ready strobe per byte, which feeds the IO

---
 rtl/spi_sniffer_sync_pkg.sv | 29 ++
 rtl/spi_sniffer_sync_edge_det.sv | 39 +++
 rtl/spi_sniffer_sync.sv | 137 +++++++++++++
 tb/tb_spi_sniffer_sync.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_sniffer_sync_pkg.sv
// Shared definitions for the SPI sniffer: config bit positions, FSM encodings
// and the shift-in helper used by the byte assembler.
package spi_sniffer_sync_pkg;

    localparam logic SNIF_IDLE   = 1'b0;
    localparam logic SNIF_ACTIVE = 1'b1;

    typedef enum logic {
        StIdle   = SNIF_IDLE,
        StActive = SNIF_ACTIVE
    } snif_state_e;

    // Bit positions inside the latched configuration vector.
    localparam int unsigned CFG_CPOL      = 0;
    localparam int unsigned CFG_CPHA      = 1;
    localparam int unsigned CFG_LSB_FIRST = 2;
    localparam int unsigned CFG_CS_HIGH   = 3;
    localparam int unsigned CFG_SRC_MISO  = 4;
    localparam int unsigned CFG_W         = 5;

    localparam logic [7:0] BYTE_CNT_MAX = 8'hFF;
    localparam logic [2:0] LAST_BIT     = 3'd7;

    function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic d,
                                            input logic lsb_first);
        return lsb_first ? {d, cur[7:1]} : {cur[6:0], d};
    endfunction

endpackage

// File: rtl/spi_sniffer_sync_edge_det.sv
// Multi-flop synchronizer for one asynchronous pin, followed by a registered
// edge detector. level_o, rise_o and fall_o are mutually cycle-aligned.
module spi_sniffer_sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic                   sync_lvl;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // The synchronizer keeps tracking the pin through reset so that the bus
    // state is already settled when reset drops.
    always_ff @(posedge clk) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        dly_q  <= sync_lvl;
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end else begin
            rise_o <= sync_lvl & ~dly_q;
            fall_o <= ~sync_lvl & dly_q;
        end
    end

    assign level_o = dly_q;

endmodule

// File: rtl/spi_sniffer_sync.sv
// Passive SPI sniffer in the system clock domain: oversamples the bus pins,
// assembles bytes and strobes each one out for the IO decode trigger.
module spi_sniffer_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic       enable_i,
    input  logic       cfg_cpol_i,
    input  logic       cfg_cpha_i,
    input  logic       cfg_lsb_first_i,
    input  logic       cfg_cs_act_high_i,
    input  logic       cfg_src_miso_i,
    input  logic       sck_i,
    input  logic       cs_i,
    input  logic       mosi_i,
    input  logic       miso_i,
    output logic [7:0] data_o,
    output logic       data_rdy_o,
    output logic [7:0] byte_cnt_o,
    output logic       frame_err_o,
    output logic       cs_active_o
);

    import spi_sniffer_sync_pkg::*;

    snif_state_e       state_q;
    logic [CFG_W-1:0]  cfg_q;
    logic [CFG_W-1:0]  cfg_live;
    logic [2:0]        bit_cnt_q;
    logic [7:0]        shift_q;
    logic [7:0]        shift_nxt;

    logic src_sel, data_raw, cs_pol, cs_act, sample_edge;
    logic sck_rise, sck_fall, cs_level, data_level;
    logic unused_sck_level, unused_cs_rise, unused_cs_fall;
    logic unused_data_rise, unused_data_fall;

    always_comb begin
        cfg_live                = '0;
        cfg_live[CFG_CPOL]      = cfg_cpol_i;
        cfg_live[CFG_CPHA]      = cfg_cpha_i;
        cfg_live[CFG_LSB_FIRST] = cfg_lsb_first_i;
        cfg_live[CFG_CS_HIGH]   = cfg_cs_act_high_i;
        cfg_live[CFG_SRC_MISO]  = cfg_src_miso_i;
    end

    // While idle the live selects are used so the data synchronizer is already
    // carrying the right line by the time the frame starts.
    assign src_sel  = (state_q == StIdle) ? cfg_src_miso_i : cfg_q[CFG_SRC_MISO];
    assign cs_pol   = (state_q == StIdle) ? cfg_cs_act_high_i : cfg_q[CFG_CS_HIGH];
    assign data_raw = src_sel ? miso_i : mosi_i;

    spi_sniffer_sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sck_det (
        .clk     (clk),
        .reset_i (reset_i),
        .d_i     (sck_i),
        .level_o (unused_sck_level),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall)
    );

    spi_sniffer_sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_cs_det (
        .clk     (clk),
        .reset_i (reset_i),
        .d_i     (cs_i),
        .level_o (cs_level),
        .rise_o  (unused_cs_rise),
        .fall_o  (unused_cs_fall)
    );

    spi_sniffer_sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_data_det (
        .clk     (clk),
        .reset_i (reset_i),
        .d_i     (data_raw),
        .level_o (data_level),
        .rise_o  (unused_data_rise),
        .fall_o  (unused_data_fall)
    );

    assign cs_act      = cs_level ~^ cs_pol;
    assign sample_edge = (cfg_q[CFG_CPOL] ^ cfg_q[CFG_CPHA]) ? sck_fall : sck_rise;
    assign shift_nxt   = shift_in(shift_q, data_level, cfg_q[CFG_LSB_FIRST]);

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q     <= StIdle;
            cfg_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_o      <= '0;
            data_rdy_o  <= 1'b0;
            byte_cnt_o  <= '0;
            frame_err_o <= 1'b0;
            cs_active_o <= 1'b0;
        end else begin
            data_rdy_o  <= 1'b0;
            frame_err_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (enable_i && cs_act) begin
                        state_q     <= StActive;
                        cfg_q       <= cfg_live;
                        bit_cnt_q   <= '0;
                        shift_q     <= '0;
                        byte_cnt_o  <= '0;
                        cs_active_o <= 1'b1;
                    end
                end
                StActive: begin
                    // Checked before the sample edge: cs release drops a
                    // coincident bit.
                    if (!enable_i || !cs_act) begin
                        state_q     <= StIdle;
                        cs_active_o <= 1'b0;
                        bit_cnt_q   <= '0;
                        frame_err_o <= (bit_cnt_q != 3'd0);
                    end else if (sample_edge) begin
                        shift_q <= shift_nxt;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q  <= '0;
                            data_o     <= shift_nxt;
                            data_rdy_o <= 1'b1;
                            if (byte_cnt_o != BYTE_CNT_MAX) begin
                                byte_cnt_o <= byte_cnt_o + 8'd1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_sniffer_sync.sv
// Directed bench for spi_sniffer_sync: drives SPI frames bit by bit and checks
// each data_rdy_o byte against a queue of expected bytes.
module tb_spi_sniffer_sync;

    logic       clk = 1'b0;
    logic       reset_i, enable_i;
    logic       cfg_cpol_i, cfg_cpha_i, cfg_lsb_first_i, cfg_cs_act_high_i, cfg_src_miso_i;
    logic       sck_i, cs_i, mosi_i, miso_i;
    logic [7:0] data_o, byte_cnt_o;
    logic       data_rdy_o, frame_err_o, cs_active_o;

    int tests = 0;
    int fails = 0;
    int rdy_cnt = 0;
    int err_cnt = 0;
    logic [7:0] exp_q[$];
    logic bus_cpol = 1'b0;
    logic bus_cpha = 1'b0;

    spi_sniffer_sync #(.SYNC_STAGES(2)) dut (
        .clk               (clk),
        .reset_i           (reset_i),
        .enable_i          (enable_i),
        .cfg_cpol_i        (cfg_cpol_i),
        .cfg_cpha_i        (cfg_cpha_i),
        .cfg_lsb_first_i   (cfg_lsb_first_i),
        .cfg_cs_act_high_i (cfg_cs_act_high_i),
        .cfg_src_miso_i    (cfg_src_miso_i),
        .sck_i             (sck_i),
        .cs_i              (cs_i),
        .mosi_i            (mosi_i),
        .miso_i            (miso_i),
        .data_o            (data_o),
        .data_rdy_o        (data_rdy_o),
        .byte_cnt_o        (byte_cnt_o),
        .frame_err_o       (frame_err_o),
        .cs_active_o       (cs_active_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every strobe pops one expected byte.
    logic prev_rdy = 1'b0;
    always @(negedge clk) begin
        if (data_rdy_o === 1'b1) begin
            rdy_cnt++;
            check("rdy_not_back_to_back", {15'd0, prev_rdy}, 16'd0);
            check("rdy_expected_pending", {15'd0, exp_q.size() != 0}, 16'd1);
            if (exp_q.size() != 0) check("data_o", {8'd0, data_o}, {8'd0, exp_q.pop_front()});
        end
        if (frame_err_o === 1'b1) err_cnt++;
        prev_rdy = (data_rdy_o === 1'b1);
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame_begin();
        sck_i = bus_cpol;
        wclk(4);
        cs_i = 1'b0;
        wclk(8);
    endtask

    task automatic frame_end();
        wclk(4);
        cs_i = 1'b1;
        wclk(8);
    endtask

    task automatic send_bit(input logic mo, input logic mi);
        if (!bus_cpha) begin
            mosi_i = mo; miso_i = mi;
            wclk(4); sck_i = ~sck_i;
            wclk(4); sck_i = ~sck_i;
        end else begin
            sck_i = ~sck_i; mosi_i = mo; miso_i = mi;
            wclk(4); sck_i = ~sck_i;
            wclk(4);
        end
    endtask

    // Bytes are given in wire order: bit 7 goes on the bus first.
    task automatic send_byte(input logic [7:0] mo, input logic [7:0] mi);
        for (int i = 7; i >= 0; i--) send_bit(mo[i], mi[i]);
    endtask

    task automatic set_mode(input logic cpol, input logic cpha);
        cfg_cpol_i = cpol; cfg_cpha_i = cpha;
        bus_cpol = cpol; bus_cpha = cpha;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0, e0;
        reset_i = 1'b1; enable_i = 1'b1;
        cfg_cpol_i = 0; cfg_cpha_i = 0; cfg_lsb_first_i = 0;
        cfg_cs_act_high_i = 0; cfg_src_miso_i = 0;
        sck_i = 0; cs_i = 1; mosi_i = 0; miso_i = 0;
        wclk(5);
        check("reset data_o", {8'd0, data_o}, 16'd0);
        check("reset data_rdy_o", {15'd0, data_rdy_o}, 16'd0);
        check("reset byte_cnt_o", {8'd0, byte_cnt_o}, 16'd0);
        check("reset frame_err_o", {15'd0, frame_err_o}, 16'd0);
        check("reset cs_active_o", {15'd0, cs_active_o}, 16'd0);
        reset_i = 1'b0;
        wclk(4);

        // Mode 0, MSB first, two bytes.
        frame_begin();
        check("t1 cs_active_o", {15'd0, cs_active_o}, 16'd1);
        exp_q.push_back(8'hA5); send_byte(8'hA5, 8'h00);
        exp_q.push_back(8'h3C); send_byte(8'h3C, 8'h00);
        frame_end();
        check("t1 byte_cnt_o", {8'd0, byte_cnt_o}, 16'd2);
        check("t1 rdy count", 16'(rdy_cnt), 16'd2);
        check("t1 cs_active_o idle", {15'd0, cs_active_o}, 16'd0);

        // Modes 1..3.
        for (int m = 1; m < 4; m++) begin
            set_mode(m[1], m[0]);
            frame_begin();
            exp_q.push_back(8'h81); send_byte(8'h81, 8'h00);
            frame_end();
        end
        check("t2 rdy count", 16'(rdy_cnt), 16'd5);

        // LSB first: wire 1,0,0,0,0,0,1,1 assembles to 0xC1.
        set_mode(1'b0, 1'b0);
        cfg_lsb_first_i = 1'b1;
        frame_begin();
        exp_q.push_back(8'h81); send_byte(8'h81, 8'h00);
        exp_q.push_back(8'hC1); send_byte(8'h83, 8'h00);
        frame_end();
        check("t2 lsb byte_cnt_o", {8'd0, byte_cnt_o}, 16'd2);
        cfg_lsb_first_i = 1'b0;

        // Partial byte then cs release.
        r0 = rdy_cnt; e0 = err_cnt;
        frame_begin();
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        frame_end();
        check("t3 frame_err pulses", 16'(err_cnt - e0), 16'd1);
        check("t3 no rdy", 16'(rdy_cnt - r0), 16'd0);
        check("t3 data_o held", {8'd0, data_o}, 16'h00C1);
        check("t3 byte_cnt_o held", {8'd0, byte_cnt_o}, 16'd0);
        frame_begin();
        exp_q.push_back(8'h55); send_byte(8'h55, 8'h00);
        frame_end();

        // Mid-frame cfg changes are ignored.
        cfg_src_miso_i = 1'b1;
        frame_begin();
        cfg_src_miso_i = 1'b0;
        cfg_cpol_i = 1'b1;
        exp_q.push_back(8'hF0); send_byte(8'h0F, 8'hF0);
        frame_end();
        check("t4 data_o", {8'd0, data_o}, 16'h00F0);
        cfg_cpol_i = 1'b0;

        // Reset mid-frame.
        r0 = rdy_cnt; e0 = err_cnt;
        frame_begin();
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        reset_i = 1'b1;
        wclk(1);
        check("t5 data_o", {8'd0, data_o}, 16'd0);
        check("t5 byte_cnt_o", {8'd0, byte_cnt_o}, 16'd0);
        check("t5 cs_active_o", {15'd0, cs_active_o}, 16'd0);
        cs_i = 1'b1;
        wclk(6);
        reset_i = 1'b0;
        wclk(4);
        check("t5 no frame_err", 16'(err_cnt - e0), 16'd0);
        check("t5 no rdy", 16'(rdy_cnt - r0), 16'd0);
        frame_begin();
        exp_q.push_back(8'h12); send_byte(8'h12, 8'h00);
        frame_end();
        check("t5 fresh data_o", {8'd0, data_o}, 16'h0012);

        // Long frame: byte counter saturates, strobes keep coming.
        r0 = rdy_cnt;
        frame_begin();
        for (int i = 0; i < 300; i++) begin
            exp_q.push_back(8'(i) ^ 8'h5A);
            send_byte(8'(i) ^ 8'h5A, 8'h00);
        end
        frame_end();
        check("t6 byte_cnt_o sat", {8'd0, byte_cnt_o}, 16'd255);
        check("t6 rdy count", 16'(rdy_cnt - r0), 16'd300);

        wclk(10);
        check("scoreboard drained", 16'(exp_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
